mac_sched: RTL and testbench
============================

MAC_SCHED -- requirements
Module: mac_sched

Interface
REQ-001 Parameter LEN_W, default 4: width of the vector-length field; maximum job length is 2^LEN_W-1.
REQ-002 Parameter ACC_W, default 20: accumulator and result width; must be at least 16.
REQ-003 clk  input  1  rising-edge system clock.
REQ-004 reset  input  1  asynchronous, active-low reset; 0 = reset asserted.
REQ-005 req  input  2  job request from requester i, bit i.
REQ-006 len0, len1  input  LEN_W each  vector length of requester 0/1, sampled at grant.
REQ-007 gnt  output  2  one-hot owner of the MAC, held for the whole job.
REQ-008 a, b  input  8 each  unsigned operand pair from the granted requester (muxed externally).
REQ-009 op_valid  input  1, op_ready  output  1  operand handshake.
REQ-010 res  output  ACC_W  dot-product result.
REQ-011 res_valid  output  1, res_ready  input  1  result handshake.
REQ-012 busy  output  1  high whenever state is not IDLE.

Function
REQ-013 States SHALL be IDLE, RUN and DONE, with a registered state and registered outputs.
REQ-014 IDLE with req!=0 SHALL grant on the next edge, latch the selected len, clear acc and set gnt.
- If len>0 the next state is RUN.
- If len==0 the next state is DONE with res=0.
REQ-015 Arbitration SHALL be round-robin.
- If both bits are set, grant the requester not served last.
- If one bit is set, grant it.
- After reset, requester 0 has priority.
REQ-016 RUN SHALL drive op_ready=1.
- Each cycle with op_valid&&op_ready: acc <= acc + a*b (16-bit unsigned product, zero-extended), count decrements.
REQ-017 Acceptance of the last operand (count==1) SHALL move to DONE, with res=final acc visible in the next cycle.
REQ-018 DONE SHALL hold res_valid=1 and res stable until res_ready=1.
- On that edge: state IDLE, gnt=0, res_valid=0, last-served pointer updated.
REQ-019 Accumulation SHALL wrap modulo 2^ACC_W, with no saturation and no overflow flag.
REQ-020 req SHALL be sampled only in IDLE; deasserting req mid-job SHALL NOT abort the job.
REQ-021 op_valid outside RUN SHALL be ignored, and op_ready SHALL be 0 outside RUN.
REQ-022 Latency: with op_valid held high, a job of length N SHALL give grant in cycle 1, operands accepted in cycles 2..N+1, and res_valid in cycle N+2.
REQ-023 A new grant SHALL need at least one IDLE cycle after the DONE handshake.
REQ-024 res_ready asserted while not in DONE SHALL have no effect.

Reset
REQ-025 reset=0 SHALL immediately force the following, regardless of clk:
- state=IDLE, gnt=0, op_ready=0, res_valid=0, busy=0
- res=0, acc=0, count=0
- round-robin pointer favouring requester 0
REQ-026 Reset asserted mid-job SHALL discard the job; no partial result is ever presented.

Structure
REQ-027 State encoding and the LEN_W/ACC_W defaults SHALL reside in a shared mac_pkg package.
REQ-028 The multiply-accumulate datapath SHALL be a sub-module mac_unit (inputs a, b, en, clr; output acc). The FSM and arbiter remain in mac_sched.

Verification
REQ-029 Single job: req=01, len0=3, operands (2,3),(4,5),(255,255) -> gnt=01, then res=65051 with res_valid in cycle 5.
REQ-030 Contention: req=11 after reset -> gnt=01 first; after handshake with req=11 still -> gnt=10; next job with req=11 -> gnt=01.
REQ-031 Zero length: req=10, len1=0 -> DONE the cycle after grant, res=0, no op_ready pulse.
REQ-032 Backpressure: len0=2, op_valid gapped (1,0,0,1), res_ready low for 3 cycles -> exactly 2 products accumulated; res and res_valid stable until res_ready.
REQ-033 Wrap: ACC_W=16, len0=2, both operands 255*255 -> res=64514.
REQ-034 Async reset: reset=0 mid-RUN, between clock edges -> all outputs 0 immediately; next job (len0=1, 7*9) -> res=63.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared definitions for the dot-product MAC scheduler: parameter defaults,
// FSM state encoding and the round-robin selection helper.
package mac_pkg;

    localparam int LEN_W_DEF = 4;
    localparam int ACC_W_DEF = 20;

    typedef logic [7:0] operand_t;

    // Encoded as plain constants so the state register stays a bit vector.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Index of the requester to serve: on contention the one not served last,
    // otherwise whichever single bit is set.
    function automatic logic rr_pick(input logic [1:0] req, input logic last);
        if (req == 2'b11) begin
            return ~last;
        end
        return req[1];
    endfunction

endpackage

// File: rtl/mac_sched_if.sv
// Request/operand/result bundle between two requesters and the MAC scheduler.
// master = requester side, slave = scheduler side.
interface mac_sched_if #(
    parameter int LEN_W = mac_pkg::LEN_W_DEF,
    parameter int ACC_W = mac_pkg::ACC_W_DEF
);
    logic [1:0]       req;
    logic [LEN_W-1:0] len0;
    logic [LEN_W-1:0] len1;
    logic [1:0]       gnt;
    logic [7:0]       a;
    logic [7:0]       b;
    logic             op_valid;
    logic             op_ready;
    logic [ACC_W-1:0] res;
    logic             res_valid;
    logic             res_ready;
    logic             busy;

    modport master (
        output req, len0, len1, a, b, op_valid, res_ready,
        input  gnt, op_ready, res, res_valid, busy
    );

    modport slave (
        input  req, len0, len1, a, b, op_valid, res_ready,
        output gnt, op_ready, res, res_valid, busy
    );

endinterface

// File: rtl/mac_unit.sv
// Multiply-accumulate datapath: 8x8 unsigned product, zero-extended and added
// into a wrapping ACC_W-bit accumulator. clr has priority over en.
module mac_unit import mac_pkg::*; #(
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  operand_t         a,
    input  operand_t         b,
    input  logic             en,
    input  logic             clr,
    output logic [ACC_W-1:0] acc
);

    logic [15:0]      prod;
    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;

    assign prod = 16'(a) * 16'(b);

    // Next accumulator value: clear at job start, add product on accepted operand.
    always_comb begin
        acc_d = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (en) begin
            acc_d = acc_q + ACC_W'(prod);
        end
    end

    // Accumulator register; sum wraps modulo 2^ACC_W with no overflow flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/mac_sched.sv
// Two-requester round-robin scheduler for a shared MAC. A granted requester
// streams len operand pairs; the dot product is then held until accepted.
// LEN_W/ACC_W must match the parameters of the connected interface.
module mac_sched import mac_pkg::*; #(
    parameter int LEN_W = LEN_W_DEF,
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic       clk,
    input  logic       reset,
    mac_sched_if.slave bus
);

    logic [1:0]       state_q, state_d;
    logic [1:0]       gnt_q, gnt_d;
    logic [LEN_W-1:0] count_q, count_d;
    logic             last_q, last_d;
    logic             op_ready_q, op_ready_d;
    logic             res_valid_q, res_valid_d;
    logic             busy_q, busy_d;

    logic             pick;
    logic [LEN_W-1:0] len_pick;
    logic             mac_en;
    logic             mac_clr;
    logic [ACC_W-1:0] acc;

    assign pick     = rr_pick(bus.req, last_q);
    assign len_pick = pick ? bus.len1 : bus.len0;

    // FSM next state, output next values and MAC controls.
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        count_d     = count_q;
        last_d      = last_q;
        op_ready_d  = op_ready_q;
        res_valid_d = res_valid_q;
        mac_en      = 1'b0;
        mac_clr     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.req != 2'b00) begin
                    gnt_d   = pick ? 2'b10 : 2'b01;
                    count_d = len_pick;
                    mac_clr = 1'b1;
                    if (len_pick != '0) begin
                        state_d    = ST_RUN;
                        op_ready_d = 1'b1;
                    end else begin
                        // Empty job: result is the freshly cleared accumulator.
                        state_d     = ST_DONE;
                        res_valid_d = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (bus.op_valid && op_ready_q) begin
                    mac_en  = 1'b1;
                    count_d = count_q - 1'b1;
                    if (count_q == LEN_W'(1)) begin
                        state_d     = ST_DONE;
                        op_ready_d  = 1'b0;
                        res_valid_d = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                if (bus.res_ready) begin
                    state_d     = ST_IDLE;
                    gnt_d       = 2'b00;
                    res_valid_d = 1'b0;
                    last_d      = gnt_q[1];
                end
            end
            default: begin
                state_d     = ST_IDLE;
                gnt_d       = 2'b00;
                op_ready_d  = 1'b0;
                res_valid_d = 1'b0;
            end
        endcase
    end

    assign busy_d = (state_d != ST_IDLE);

    // State and registered outputs; reset favours requester 0 next.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            gnt_q       <= 2'b00;
            count_q     <= '0;
            last_q      <= 1'b1;
            op_ready_q  <= 1'b0;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            count_q     <= count_d;
            last_q      <= last_d;
            op_ready_q  <= op_ready_d;
            res_valid_q <= res_valid_d;
            busy_q      <= busy_d;
        end
    end

    mac_unit #(
        .ACC_W (ACC_W)
    ) u_mac (
        .clk   (clk),
        .reset (reset),
        .a     (bus.a),
        .b     (bus.b),
        .en    (mac_en),
        .clr   (mac_clr),
        .acc   (acc)
    );

    // The accumulator is only read while res_valid is high, where it is final.
    assign bus.gnt       = gnt_q;
    assign bus.op_ready  = op_ready_q;
    assign bus.res_valid = res_valid_q;
    assign bus.busy      = busy_q;
    assign bus.res       = acc;

endmodule

// File: tb/tb_mac_sched.sv
// Self-checking bench for mac_sched: two instances (ACC_W=20 and ACC_W=16)
// share identical stimulus; expected values come from a job-level model.
module tb_mac_sched;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] req;
    logic [3:0] len0, len1;
    logic [7:0] a, b;
    logic       op_valid, res_ready;

    int checks = 0;
    int errors = 0;

    logic        last_served;
    logic [7:0]  da [16];
    logic [7:0]  db [16];
    bit          use_dir;
    bit          use_pat;
    logic [63:0] vpat;

    mac_sched_if #(.LEN_W(4), .ACC_W(20)) bus20 ();
    mac_sched_if #(.LEN_W(4), .ACC_W(16)) bus16 ();

    assign bus20.req = req;       assign bus16.req = req;
    assign bus20.len0 = len0;     assign bus16.len0 = len0;
    assign bus20.len1 = len1;     assign bus16.len1 = len1;
    assign bus20.a = a;           assign bus16.a = a;
    assign bus20.b = b;           assign bus16.b = b;
    assign bus20.op_valid = op_valid;   assign bus16.op_valid = op_valid;
    assign bus20.res_ready = res_ready; assign bus16.res_ready = res_ready;

    mac_sched #(.LEN_W(4), .ACC_W(20)) dut20 (.clk(clk), .reset(reset), .bus(bus20));
    mac_sched #(.LEN_W(4), .ACC_W(16)) dut16 (.clk(clk), .reset(reset), .bus(bus16));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_ctl(input string tag, input logic [1:0] eg, input logic eor,
                           input logic erv, input logic eb);
        chk({tag, ".gnt20"}, 32'(bus20.gnt), 32'(eg));
        chk({tag, ".gnt16"}, 32'(bus16.gnt), 32'(eg));
        chk({tag, ".op_ready20"}, 32'(bus20.op_ready), 32'(eor));
        chk({tag, ".op_ready16"}, 32'(bus16.op_ready), 32'(eor));
        chk({tag, ".res_valid20"}, 32'(bus20.res_valid), 32'(erv));
        chk({tag, ".res_valid16"}, 32'(bus16.res_valid), 32'(erv));
        chk({tag, ".busy20"}, 32'(bus20.busy), 32'(eb));
        chk({tag, ".busy16"}, 32'(bus16.busy), 32'(eb));
    endtask

    // One complete job from request to result handshake, checked cycle by cycle.
    task automatic run_job(input logic [1:0] rq, input logic [3:0] l0, input logic [3:0] l1,
                           input int vpct, input int rdly, input bit keep);
        logic        idx;
        logic [3:0]  n_len;
        logic [1:0]  eg;
        logic [63:0] sum;
        int          n, cyc;
        idx   = (rq == 2'b11) ? ~last_served : rq[1];
        n_len = idx ? l1 : l0;
        eg    = idx ? 2'b10 : 2'b01;
        req = rq; len0 = l0; len1 = l1;
        op_valid = 1'($urandom); a = 8'($urandom); b = 8'($urandom);
        res_ready = 1'($urandom);
        @(posedge clk); #1;
        if (!keep) req = 2'b00;
        len0 = 4'($urandom); len1 = 4'($urandom);
        chk_ctl("grant", eg, n_len != 0, n_len == 0, 1'b1);
        sum = 0; n = 0; cyc = 0;
        while (n < int'(n_len) && cyc < 64) begin
            chk_ctl("run", eg, 1'b1, 1'b0, 1'b1);
            op_valid  = use_pat ? vpat[cyc] : ($urandom_range(0, 99) < vpct);
            a         = use_dir ? da[n] : 8'($urandom);
            b         = use_dir ? db[n] : 8'($urandom);
            res_ready = 1'($urandom);
            @(posedge clk); #1;
            if (op_valid) begin
                sum += 64'(a) * 64'(b);
                n++;
            end
            cyc++;
        end
        if (n < int'(n_len)) chk("run_timeout", n, 32'(n_len));
        res_ready = 1'b0;
        for (int i = 0; i <= rdly; i++) begin
            chk_ctl("done", eg, 1'b0, 1'b1, 1'b1);
            chk("res20", 32'(bus20.res), 32'(sum[19:0]));
            chk("res16", 32'(bus16.res), 32'(sum[15:0]));
            op_valid = 1'b1; a = 8'($urandom); b = 8'($urandom);
            if (i < rdly) begin
                @(posedge clk); #1;
            end
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0; op_valid = 1'b0;
        chk_ctl("handshake", 2'b00, 1'b0, 1'b0, 1'b0);
        last_served = idx;
        $display("job req=%b len=%0d gnt=%b sum20=%0d sum16=%0d", rq, n_len, eg, sum[19:0], sum[15:0]);
    endtask

    initial begin
        req = 2'b00; len0 = 4'd0; len1 = 4'd0; a = 8'd0; b = 8'd0;
        op_valid = 1'b0; res_ready = 1'b0;
        use_dir = 1'b0; use_pat = 1'b0; vpat = '0;
        last_served = 1'b1;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_ctl("reset", 2'b00, 1'b0, 1'b0, 1'b0);
        chk("reset.res20", 32'(bus20.res), 32'd0);
        chk("reset.res16", 32'(bus16.res), 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;

        // Single job with known operands: 6 + 20 + 65025 = 65051.
        use_dir = 1'b1;
        da[0] = 8'd2;   db[0] = 8'd3;
        da[1] = 8'd4;   db[1] = 8'd5;
        da[2] = 8'd255; db[2] = 8'd255;
        run_job(2'b01, 4'd3, 4'd9, 100, 0, 1'b0);
        use_dir = 1'b0;

        // Contention: alternating grants while both requests stay high.
        run_job(2'b11, 4'($urandom_range(1, 4)), 4'($urandom_range(1, 4)), 100, 1, 1'b1);
        run_job(2'b11, 4'($urandom_range(1, 4)), 4'($urandom_range(1, 4)), 100, 0, 1'b1);
        run_job(2'b11, 4'($urandom_range(1, 4)), 4'($urandom_range(1, 4)), 100, 0, 1'b1);

        // Zero-length job on requester 1.
        run_job(2'b10, 4'd5, 4'd0, 100, 1, 1'b0);

        // Gapped operands and result backpressure.
        use_pat = 1'b1; vpat = 64'b1001;
        run_job(2'b01, 4'd2, 4'd0, 100, 3, 1'b0);
        use_pat = 1'b0;

        // Wrap: 2*65025 = 130050; modulo 2^16 gives 64514.
        use_dir = 1'b1;
        da[0] = 8'd255; db[0] = 8'd255;
        da[1] = 8'd255; db[1] = 8'd255;
        run_job(2'b01, 4'd2, 4'd0, 100, 0, 1'b0);
        use_dir = 1'b0;

        // Asynchronous reset between clock edges in the middle of a job.
        req = 2'b01; len0 = 4'd5; op_valid = 1'b0;
        @(posedge clk); #1;
        req = 2'b00; op_valid = 1'b1; a = 8'd17; b = 8'd33;
        @(posedge clk); #1;
        op_valid = 1'b0;
        #2 reset = 1'b0;
        #1;
        chk_ctl("async_rst", 2'b00, 1'b0, 1'b0, 1'b0);
        chk("async_rst.res20", 32'(bus20.res), 32'd0);
        chk("async_rst.res16", 32'(bus16.res), 32'd0);
        reset = 1'b1;
        last_served = 1'b1;
        @(posedge clk); #1;
        use_dir = 1'b1;
        da[0] = 8'd7; db[0] = 8'd9;
        run_job(2'b01, 4'd1, 4'd0, 100, 0, 1'b0);
        use_dir = 1'b0;

        // Randomized jobs.
        for (int j = 0; j < 40; j++) begin
            run_job(2'($urandom_range(1, 3)), 4'($urandom), 4'($urandom),
                    $urandom_range(30, 100), $urandom_range(0, 3), 1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
